tmds_timing_gen: RTL

Transmit-side video timing generator: produces hsync, vsync and data-enable for the TMDS encoder path, plus the same counter and coordinate outputs the receive-side timing recovery provides. Default parameters give 1280x720p60 (1650x750 total). A run/stop control lets the sink path start output only once the pixel FIFO is primed. A frame always completes before the block stops.

---
 rtl/tmds_timing_gen.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/tmds_timing_gen.sv
// ---------------------------------------------------------------------------
// tmds_timing_gen
//   Transmit-side video timing generator for the TMDS encoder path. Produces
//   hsync, vsync and data-enable, plus raw line/frame counters and active
//   video coordinates. Defaults give 1280x720p60 (1650x750 total).
//
//   A run/stop control lets the sink path wait until its pixel FIFO is
//   primed. Once started, a frame always completes: run is only looked at
//   in the last pixel of a frame.
//
// Ports
//   tx0_pclk     pixel clock, sole clock
//   rstbtn_n     synchronous reset, active low
//   run          start / keep generating frames
//   tx0_hsync    horizontal sync (active level HSYNC_POL)
//   tx0_vsync    vertical sync (active level VSYNC_POL)
//   tx0_de       active-video enable
//   video_req    pixel request to the upstream FIFO
//   frame_start  one-cycle pulse on the first pixel of each frame
//   busy         generator is in RUN
//   hcounter     pixel position in line, 0..H_TOTAL-1
//   vcounter     line position in frame, 0..V_TOTAL-1
//   video_hcnt   active x coordinate, 0 outside active video
//   video_vcnt   active y coordinate, 0 outside active video
//
// Build option
//   TMDS_TIMING_GEN_PREFETCH_EN
//     defined    : video_req leads tx0_de by one cycle, so a registered FIFO
//                  read lands aligned with de.
//     undefined  : video_req is identical to tx0_de.
// ---------------------------------------------------------------------------
module tmds_timing_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic        tx0_pclk,
  input  logic        rstbtn_n,
  input  logic        run,
  output logic        tx0_hsync,
  output logic        tx0_vsync,
  output logic        tx0_de,
  output logic        video_req,
  output logic        frame_start,
  output logic        busy,
  output logic [10:0] hcounter,
  output logic [10:0] vcounter,
  output logic [10:0] video_hcnt,
  output logic [10:0] video_vcnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;
  logic   start_pend;   // run seen in IDLE; first pixel goes out next cycle

  // ---- raster helpers (pure functions of a position) ----------------------
  function automatic logic [10:0] step_h(input logic [10:0] h);
    return (h == H_LAST) ? 11'd0 : h + 11'd1;
  endfunction

  function automatic logic [10:0] step_v(input logic [10:0] h, input logic [10:0] v);
    if (h != H_LAST) return v;
    return (v == V_LAST) ? 11'd0 : v + 11'd1;
  endfunction

  function automatic logic in_active(input logic [10:0] h, input logic [10:0] v);
    return (h < H_ACT) && (v < V_ACT);
  endfunction

  // ---- next position / next state -----------------------------------------
  logic        go_n;     // next cycle is a RUN cycle
  logic        pend_n;
  logic [10:0] h_n;
  logic [10:0] v_n;
  logic        de_n;
  logic        req_n;
  logic        frame_end;

  assign frame_end = (hcounter == H_LAST) && (vcounter == V_LAST);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a value held and infer a latch.
  always_comb begin
    go_n   = 1'b0;
    pend_n = 1'b0;
    h_n    = '0;
    v_n    = '0;
    unique case (state)
      ST_IDLE: begin
        if (start_pend) go_n = 1'b1;   // enter RUN at position 0,0
        else            pend_n = run;
      end
      ST_RUN: begin
        // run only matters on the last pixel of the frame
        if (!(frame_end && !run)) begin
          go_n = 1'b1;
          h_n  = step_h(hcounter);
          v_n  = step_v(hcounter, vcounter);
        end
      end
      default: ;
    endcase
  end

  assign de_n = go_n && in_active(h_n, v_n);

`ifdef TMDS_TIMING_GEN_PREFETCH_EN
  // Request reflects the pixel one position ahead. While pending start the
  // next shown pixel is 0,0, which is always active. On the last pixel of a
  // frame the request assumes the frame sequence continues, as run is not
  // known until that cycle.
  assign req_n = pend_n || (go_n && in_active(step_h(h_n), step_v(h_n, v_n)));
`else
  assign req_n = de_n;
`endif

  // ---- registered state and outputs ---------------------------------------
  // All outputs are loaded from the same next position, so sync, de and
  // coordinates always describe the counters shown in the same cycle.
  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge tx0_pclk) begin
    if (!rstbtn_n) begin
      state       <= ST_IDLE;
      start_pend  <= 1'b0;
      hcounter    <= '0;
      vcounter    <= '0;
      video_hcnt  <= '0;
      video_vcnt  <= '0;
      tx0_de      <= 1'b0;
      video_req   <= 1'b0;
      frame_start <= 1'b0;
      tx0_hsync   <= ~HSYNC_POL;
      tx0_vsync   <= ~VSYNC_POL;
    end else begin
      state       <= go_n ? ST_RUN : ST_IDLE;
      start_pend  <= pend_n;
      hcounter    <= h_n;
      vcounter    <= v_n;
      video_hcnt  <= de_n ? h_n : 11'd0;
      video_vcnt  <= de_n ? v_n : 11'd0;
      tx0_de      <= de_n;
      video_req   <= req_n;
      frame_start <= go_n && (h_n == 11'd0) && (v_n == 11'd0);
      tx0_hsync   <= (go_n && (h_n >= H_SYNC_BEG) && (h_n < H_SYNC_END)) ?
                     HSYNC_POL : ~HSYNC_POL;
      tx0_vsync   <= (go_n && (v_n >= V_SYNC_BEG) && (v_n < V_SYNC_END)) ?
                     VSYNC_POL : ~VSYNC_POL;
    end
  end

  assign busy = (state == ST_RUN);

endmodule
